// File: rtl/bcd_counter_display_if.sv
// Control and display bundle for bcd_counter_display.
// The master side drives the count controls; the slave side is the counter itself.
interface bcd_counter_display_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    en;
  logic                    up_down;
  logic                    clr;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_bcd;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic                    tick;
  logic                    wrap;
  logic [6:0]              seg;
  logic [7:0]              an;

  modport master (
    output en, up_down, clr, load, load_bcd,
    input  count_bcd, tick, wrap, seg, an
  );

  modport slave (
    input  en, up_down, clr, load, load_bcd,
    output count_bcd, tick, wrap, seg, an
  );
endinterface

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with tick prescaler and scanned 7-segment driver.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits on the display.
module bcd_counter_display #(
  parameter int          NUM_DIGITS  = 2,
  parameter logic [31:0] MAX_BCD     = 32'h0000_0059,
  parameter int          TICK_DIV    = 100_000_000,
  parameter int          REFRESH_DIV = 100_000
) (
  input logic                   clk,
  input logic                   rst_n,
  bcd_counter_display_if.slave  bus
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [W-1:0]  MAX_VAL      = MAX_BCD[W-1:0];
  localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST    = SW'(NUM_DIGITS - 1);

  logic [TW-1:0]         tick_cnt;
  logic                  tick_q;
  logic [W-1:0]          count_q;
  logic [W-1:0]          count_next;
  logic                  wrap_q;
  logic                  wrap_next;
  logic [RW-1:0]         refresh_cnt;
  logic [SW-1:0]         scan_idx;
  logic [6:0]            seg_q;
  logic [6:0]            seg_next;
  logic [7:0]            an_q;
  logic [7:0]            an_next;
  logic [3:0]            digit;
  logic                  digit_blank;
  logic [NUM_DIGITS-1:0] blank_mask;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A load is accepted only if every nibble is a decimal digit and it does not exceed the wrap value.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = (v <= MAX_VAL);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Free-running prescaler; tick is high the cycle after the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= (tick_cnt == TICK_LAST);
      if (tick_cnt == TICK_LAST) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_comb begin
    count_next = count_q;
    wrap_next  = 1'b0;
    if (bus.clr) begin
      count_next = '0;
    end else if (bus.load) begin
      if (bcd_valid(bus.load_bcd)) count_next = bus.load_bcd;
    end else if (tick_q && bus.en) begin
      if (bus.up_down) begin
        if (count_q == MAX_VAL) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end else begin
          count_next = bcd_inc(count_q);
        end
      end else begin
        if (count_q == '0) begin
          count_next = MAX_VAL;
          wrap_next  = 1'b1;
        end else begin
          count_next = bcd_dec(count_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_next;
      wrap_q  <= wrap_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == SCAN_LAST) ? '0 : scan_idx + SW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;

  // Walk down from the most significant digit; digit 0 is never blanked.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run      = zero_run & (count_q[4*i +: 4] == 4'd0);
      blank_mask[i] = zero_run;
    end
  end
`else
  assign blank_mask = '0;
`endif

  always_comb begin
    digit       = 4'd0;
    digit_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == SW'(i)) begin
        digit       = count_q[4*i +: 4];
        digit_blank = blank_mask[i];
      end
    end
  end

  always_comb begin
    seg_next = 7'h7F;
    an_next  = 8'hFF;
    if (!digit_blank) begin
      seg_next = seg_decode(digit);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (scan_idx == SW'(i)) an_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'h7F;
      an_q  <= 8'hFF;
    end else begin
      seg_q <= seg_next;
      an_q  <= an_next;
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.tick      = tick_q;
  assign bus.wrap      = wrap_q;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display: 2 digits, wrap 59, tick every 4 clks, 2-clk scan slots.
// Honours LEADING_ZERO_BLANK_EN in the blanking scenario.
module tb_bcd_counter_display;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  bcd_counter_display_if #(.NUM_DIGITS(2)) bus ();

  bcd_counter_display #(
    .NUM_DIGITS (2),
    .MAX_BCD    (32'h0000_0059),
    .TICK_DIV   (4),
    .REFRESH_DIV(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Steps until a negedge where tick is high, giving up after 16 clocks.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.tick !== 1'b1 && n < 16);
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load_bcd = v;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    vectors++;
    if (bus.count_bcd !== 8'h00) begin
      miscompares++; $display("[TB] FAIL reset_count: got %h, expected 00", bus.count_bcd);
    end
    vectors++;
    if (bus.tick !== 1'b0 || bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_pulses: got tick=%b wrap=%b, expected 0/0", bus.tick, bus.wrap);
    end
    vectors++;
    if (bus.seg !== 7'h7F || bus.an !== 8'hFF) begin
      miscompares++; $display("[TB] FAIL reset_display: got seg=%h an=%h, expected 7f/ff", bus.seg, bus.an);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    int ticks;
    int since;
    int wraps;
    int guard;
    bus.en      = 1'b1;
    bus.up_down = 1'b1;
    ticks = 0; since = 0; wraps = 0; guard = 0;
    while (ticks < 60 && guard < 400) begin
      step();
      guard++;
      since++;
      if (bus.wrap === 1'b1) wraps++;
      if (bus.tick === 1'b1) begin
        vectors++;
        if (since != 4) begin
          miscompares++; $display("[TB] FAIL tick_period: got %0d clks, expected 4", since);
        end
        vectors++;
        if (bus.count_bcd !== to_bcd(ticks % 60)) begin
          miscompares++; $display("[TB] FAIL count_up: got %h, expected %h", bus.count_bcd, to_bcd(ticks % 60));
        end
        ticks++;
        since = 0;
      end
    end
    vectors++;
    if (ticks != 60) begin
      miscompares++; $display("[TB] FAIL tick_timeout: got %0d ticks, expected 60", ticks);
    end
    step();
    if (bus.wrap === 1'b1) wraps++;
    vectors++;
    if (bus.count_bcd !== 8'h00 || bus.wrap !== 1'b1) begin
      miscompares++; $display("[TB] FAIL up_wrap: got count=%h wrap=%b, expected 00/1", bus.count_bcd, bus.wrap);
    end
    vectors++;
    if (wraps != 1) begin
      miscompares++; $display("[TB] FAIL wrap_pulses: got %0d, expected 1", wraps);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_carry_borrow();
    int n;
    do_load(8'h19);
    vectors++;
    if (bus.count_bcd !== 8'h19) begin
      miscompares++; $display("[TB] FAIL load_19: got %h, expected 19", bus.count_bcd);
    end
    wait_tick(n);
    bus.en = 1'b1; bus.up_down = 1'b1;
    step();
    bus.en = 1'b0;
    vectors++;
    if (bus.count_bcd !== 8'h20 || bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL carry: got count=%h wrap=%b, expected 20/0", bus.count_bcd, bus.wrap);
    end

    do_load(8'h20);
    wait_tick(n);
    bus.en = 1'b1; bus.up_down = 1'b0;
    step();
    bus.en = 1'b0;
    vectors++;
    if (bus.count_bcd !== 8'h19 || bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL borrow: got count=%h wrap=%b, expected 19/0", bus.count_bcd, bus.wrap);
    end

    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    vectors++;
    if (bus.count_bcd !== 8'h00) begin
      miscompares++; $display("[TB] FAIL clear: got %h, expected 00", bus.count_bcd);
    end
    wait_tick(n);
    bus.en = 1'b1; bus.up_down = 1'b0;
    step();
    bus.en = 1'b0;
    vectors++;
    if (bus.count_bcd !== 8'h59 || bus.wrap !== 1'b1) begin
      miscompares++; $display("[TB] FAIL down_wrap: got count=%h wrap=%b, expected 59/1", bus.count_bcd, bus.wrap);
    end
    step();
    vectors++;
    if (bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL wrap_width: got %b, expected 0", bus.wrap);
    end
  endtask

  task automatic test_invalid_load();
    int n;
    do_load(8'h12);
    vectors++;
    if (bus.count_bcd !== 8'h12) begin
      miscompares++; $display("[TB] FAIL load_12: got %h, expected 12", bus.count_bcd);
    end
    do_load(8'h5A);
    vectors++;
    if (bus.count_bcd !== 8'h12 || bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_5a: got count=%h wrap=%b, expected 12/0", bus.count_bcd, bus.wrap);
    end
    do_load(8'h60);
    vectors++;
    if (bus.count_bcd !== 8'h12 || bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_60: got count=%h wrap=%b, expected 12/0", bus.count_bcd, bus.wrap);
    end
    do_load(8'h59);
    vectors++;
    if (bus.count_bcd !== 8'h59) begin
      miscompares++; $display("[TB] FAIL load_59: got %h, expected 59", bus.count_bcd);
    end

    // clr, load and a counting tick together: clear wins, nothing else happens.
    wait_tick(n);
    vectors++;
    if (bus.tick !== 1'b1) begin
      miscompares++; $display("[TB] FAIL tick_timeout: got tick=%b, expected 1", bus.tick);
    end
    bus.clr = 1'b1; bus.load = 1'b1; bus.load_bcd = 8'h33;
    bus.en  = 1'b1; bus.up_down = 1'b1;
    step();
    bus.clr = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
    vectors++;
    if (bus.count_bcd !== 8'h00 || bus.wrap !== 1'b0) begin
      miscompares++; $display("[TB] FAIL clr_priority: got count=%h wrap=%b, expected 00/0", bus.count_bcd, bus.wrap);
    end
  endtask

  task automatic test_enable_hold();
    int n;
    do_load(8'h42);
    bus.en = 1'b0;
    wait_tick(n);
    for (int k = 0; k < 5; k++) begin
      wait_tick(n);
      vectors++;
      if (n != 4) begin
        miscompares++; $display("[TB] FAIL hold_tick_period: got %0d clks, expected 4", n);
      end
      vectors++;
      if (bus.count_bcd !== 8'h42) begin
        miscompares++; $display("[TB] FAIL hold_count: got %h, expected 42", bus.count_bcd);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.en = 1'b1; bus.up_down = 1'b1;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.count_bcd !== 8'h00 || bus.tick !== 1'b0 || bus.wrap !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_count: got count=%h tick=%b wrap=%b, expected 00/0/0", bus.count_bcd, bus.tick, bus.wrap);
    end
    vectors++;
    if (bus.an !== 8'hFF || bus.seg !== 7'h7F) begin
      miscompares++; $display("[TB] FAIL async_reset_display: got an=%h seg=%h, expected ff/7f", bus.an, bus.seg);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b0;
    step();
    vectors++;
    if (bus.an !== 8'hFE || bus.seg !== 7'h40) begin
      miscompares++; $display("[TB] FAIL first_scan: got an=%h seg=%h, expected fe/40", bus.an, bus.seg);
    end
  endtask

  task automatic test_scan();
    logic [7:0] an_hist [0:8];
    logic [6:0] exp_seg;
    bus.en = 1'b0;
    do_load(8'h37);
    step(); step();
    for (int k = 0; k < 9; k++) begin
      an_hist[k] = bus.an;
      vectors++;
      if (bus.an !== 8'hFE && bus.an !== 8'hFD) begin
        miscompares++; $display("[TB] FAIL scan_an: got %h, expected fe or fd", bus.an);
      end
      vectors++;
      if (bus.an[7:2] !== 6'h3F) begin
        miscompares++; $display("[TB] FAIL scan_unused_an: got %h, expected 3f", bus.an[7:2]);
      end
      exp_seg = (bus.an === 8'hFD) ? 7'h30 : 7'h78;
      vectors++;
      if (bus.seg !== exp_seg) begin
        miscompares++; $display("[TB] FAIL scan_seg: got %h with an=%h, expected %h", bus.seg, bus.an, exp_seg);
      end
      step();
    end
    for (int k = 0; k < 7; k++) begin
      vectors++;
      if (an_hist[k+2] === an_hist[k]) begin
        miscompares++; $display("[TB] FAIL scan_period: got an=%h two clks after %h, expected the other digit", an_hist[k+2], an_hist[k]);
      end
    end
  endtask

  task automatic test_blanking();
    logic [7:0] exp_an1;
    logic [6:0] exp_seg1;
    int         d0_slots;
`ifdef LEADING_ZERO_BLANK_EN
    exp_an1  = 8'hFF;
    exp_seg1 = 7'h7F;
`else
    exp_an1  = 8'hFD;
    exp_seg1 = 7'h40;
`endif
    d0_slots = 0;
    bus.en = 1'b0;
    do_load(8'h05);
    step(); step();
    for (int k = 0; k < 4; k++) begin
      if (bus.an === 8'hFE) begin
        d0_slots++;
        vectors++;
        if (bus.seg !== 7'h12) begin
          miscompares++; $display("[TB] FAIL blank_digit0: got seg=%h, expected 12", bus.seg);
        end
      end else begin
        vectors++;
        if (bus.an !== exp_an1 || bus.seg !== exp_seg1) begin
          miscompares++;
          $display("[TB] FAIL blank_digit1: got an=%h seg=%h, expected %h/%h", bus.an, bus.seg, exp_an1, exp_seg1);
        end
      end
      step();
    end
    vectors++;
    if (d0_slots != 2) begin
      miscompares++; $display("[TB] FAIL blank_d0_slots: got %0d, expected 2", d0_slots);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.up_down  = 1'b1;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_bcd = 8'h00;
    @(negedge clk);
    $display("[TB] starting directed tests");
    test_reset();
    test_count_up();
    test_carry_borrow();
    test_invalid_load();
    test_enable_hold();
    test_async_reset();
    test_scan();
    test_blanking();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
